// File: rtl/string_hw_pkg.sv
// Shared types for the string accelerator job path: scheduler states and the job record.
package string_hw_pkg;

  localparam int WORD_W  = 32;
  localparam int FIELD_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2,
    RESP    = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [WORD_W-1:0]  a;
    logic [WORD_W-1:0]  b;
    logic [FIELD_W-1:0] index;
    logic [FIELD_W-1:0] length;
  } string_job_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
// Zero latency; grant is all-zero when disabled or nothing is requesting.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    if (enable) begin
      for (int i = NUM_REQ; i >= 1; i--) begin
        idx = ID_W'((int'(ptr) + i) % NUM_REQ);
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          grant_id   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/string_job_scheduler.sv
// Shares one string core among NUM_REQ requesters: accept, go/done handshake with watchdog, 1-cycle response.
// Accept-to-response is k+4 cycles for a core answering k cycles after go; responses have no backpressure.
module string_job_scheduler
  import string_hw_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WORD_W-1:0]  req_a,
  input  logic [NUM_REQ*WORD_W-1:0]  req_b,
  input  logic [NUM_REQ*FIELD_W-1:0] req_index,
  input  logic [NUM_REQ*FIELD_W-1:0] req_length,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WORD_W-1:0]          rsp_result,
  output logic                       rsp_error,
  output logic                       core_go,
  output logic [WORD_W-1:0]          core_a,
  output logic [WORD_W-1:0]          core_b,
  output logic [FIELD_W-1:0]         core_index,
  output logic [FIELD_W-1:0]         core_length,
  input  logic                       core_done,
  input  logic [WORD_W-1:0]          core_result,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  sched_state_t       state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, arb_id;
  logic [NUM_REQ-1:0] arb_grant;
  logic [CNT_W-1:0]   wd_cnt;
  logic               timeout_hit;
  string_job_t        job_q, job_sel;

  logic [WORD_W-1:0]  a_arr   [NUM_REQ];
  logic [WORD_W-1:0]  b_arr   [NUM_REQ];
  logic [FIELD_W-1:0] idx_arr [NUM_REQ];
  logic [FIELD_W-1:0] len_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]   = req_a[g*WORD_W +: WORD_W];
    assign b_arr[g]   = req_b[g*WORD_W +: WORD_W];
    assign idx_arr[g] = req_index[g*FIELD_W +: FIELD_W];
    assign len_arr[g] = req_length[g*FIELD_W +: FIELD_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .enable   (state == IDLE),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

  always_comb begin
    job_sel.a      = a_arr[arb_id];
    job_sel.b      = b_arr[arb_id];
    job_sel.index  = idx_arr[arb_id];
    job_sel.length = len_arr[arb_id];
  end

  assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|arb_grant) state_nxt = RUN;
      RUN:     if (core_done || timeout_hit) state_nxt = RELEASE;
      RELEASE: if (!core_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Done is tested before the watchdog so a coincident completion keeps its result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      job_q      <= '0;
      wd_cnt     <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|arb_grant) begin
          job_q    <= job_sel;
          grant_id <= arb_id;
          rr_ptr   <= arb_id;
          wd_cnt   <= '0;
        end
        RUN: if (core_done) begin
          rsp_result <= core_result;
          rsp_error  <= 1'b0;
        end else if (timeout_hit) begin
          rsp_result <= '0;
          rsp_error  <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + CNT_W'(1);
        end
        RELEASE: if (!core_done) wd_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign req_ready   = arb_grant;
  assign core_go     = (state == RUN);
  assign busy        = (state != IDLE);
  assign rsp_valid   = (state == RESP) ? (NUM_REQ'(1) << grant_id) : '0;
  assign core_a      = job_q.a;
  assign core_b      = job_q.b;
  assign core_index  = job_q.index;
  assign core_length = job_q.length;

endmodule

// File: tb/tb_string_job_scheduler.sv
// Directed bench for string_job_scheduler: behavioural core model plus hand-computed expectations.
module tb_string_job_scheduler;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0, req_b = '0;
  logic [11:0]  req_index = '0, req_length = '0;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_result;
  logic         rsp_error;
  logic         core_go;
  logic [31:0]  core_a, core_b;
  logic [2:0]   core_index, core_length;
  logic         core_done = 1'b0;
  logic [31:0]  core_result = '0;
  logic         busy;
  logic [1:0]   grant_id;

  string_job_scheduler #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_index(req_index), .req_length(req_length),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .core_go(core_go), .core_a(core_a), .core_b(core_b),
    .core_index(core_index), .core_length(core_length),
    .core_done(core_done), .core_result(core_result),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Core model: done rises when go has been high cm_k+1 cycles, falls cm_hold cycles after go drops.
  int          cm_k = 5, cm_hold = 1;
  bit          cm_hang = 1'b0;
  logic [31:0] cm_result = '0;

  initial begin
    int go_cnt, rel_cnt;
    go_cnt = 0; rel_cnt = 0;
    forever begin
      @(negedge clk);
      if (core_go) begin
        go_cnt++;
        rel_cnt = 0;
        if (!cm_hang && go_cnt == cm_k + 1) begin
          core_done   = 1'b1;
          core_result = cm_result;
        end
      end else if (core_done) begin
        rel_cnt++;
        if (rel_cnt > cm_hold) begin
          core_done   = 1'b0;
          core_result = '0;
        end
      end else begin
        go_cnt = 0; rel_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] idx, input logic [2:0] len);
    req_a[32*i +: 32]     = a;
    req_b[32*i +: 32]     = b;
    req_index[3*i +: 3]   = idx;
    req_length[3*i +: 3]  = len;
  endtask

  // Waits (bounded) for an accept strobe, checks the winner, then steps into the first RUN cycle.
  task automatic do_accept(input int w, output int waited);
    waited = 0;
    #1;
    while (req_ready == '0 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    check("accept_ready", req_ready, 32'(4'b0001 << w));
    @(negedge clk);
    check("accept_grant_id", grant_id, w);
    check("accept_core_go", core_go, 1);
  endtask

  int bad_ready;

  // Called in the first RUN cycle; records go length, response cycle (relative to accept) and payload.
  task automatic wait_rsp(output int go_cyc, output int rsp_n, output logic [3:0] rv,
                          output logic [31:0] res, output logic err,
                          output logic one_cyc, output logic regrant);
    bit go_fell;
    int n;
    go_cyc = 0; rsp_n = -1; rv = '0; res = '0; err = 1'bx;
    one_cyc = 1'b0; regrant = 1'b0; go_fell = 1'b0;
    n = 1;
    while (n < 60) begin
      if (core_go) begin
        go_cyc++;
        if (go_fell) regrant = 1'b1;
      end else if (go_cyc > 0) go_fell = 1'b1;
      if (busy && req_ready != '0) bad_ready++;
      if (rsp_valid != '0) begin
        rsp_n = n; rv = rsp_valid; res = rsp_result; err = rsp_error;
        @(negedge clk);
        one_cyc = (rsp_valid == '0);
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  int          waited, go_cyc, rsp_n;
  logic [3:0]  rv;
  logic [31:0] res;
  logic        err, one_cyc, regrant;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_core_go", core_go, 0);
    check("rst_core_a", core_a, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single job from requester 2, core answers after 5 cycles
    bad_ready = 0;
    cm_k = 5; cm_hold = 1; cm_result = 32'h41454647;
    set_req(2, 32'h41424344, 32'h45464748, 3'd1, 3'd2);
    req_valid = 4'b0100;
    do_accept(2, waited);
    check("t1_accept_wait", waited, 0);
    req_valid = 4'b0000;
    set_req(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7, 3'd7);
    check("t1_core_a", core_a, 32'h41424344);
    check("t1_core_b", core_b, 32'h45464748);
    check("t1_core_index", core_index, 1);
    check("t1_core_length", core_length, 2);
    wait_rsp(go_cyc, rsp_n, rv, res, err, one_cyc, regrant);
    check("t1_go_cycles", go_cyc, 6);
    check("t1_rsp_cycle", rsp_n, 9);
    check("t1_rsp_valid", rv, 4'b0100);
    check("t1_rsp_result", res, 32'h41454647);
    check("t1_rsp_error", err, 0);
    check("t1_rsp_one_cycle", one_cyc, 1);
    check("t1_result_hold", rsp_result, 32'h41454647);

    // All four requesters valid from reset: strict rotation 0,1,2,3,0,1,2,3
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 32'h1000 + i, 32'h2000 + i, 3'(i), 3'(i + 1));
    cm_k = 1;
    bad_ready = 0;
    req_valid = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      cm_result = 32'hA000 + j;
      do_accept(j % 4, waited);
      check("t2_core_a", core_a, 32'h1000 + (j % 4));
      wait_rsp(go_cyc, rsp_n, rv, res, err, one_cyc, regrant);
      check("t2_rsp_owner", rv, 32'(4'b0001 << (j % 4)));
      check("t2_rsp_result", res, 32'hA000 + j);
    end
    req_valid = 4'b0000;
    check("t2_no_ready_while_busy", bad_ready, 0);

    // Hung core: watchdog aborts after 16 go cycles, then a normal job follows
    cm_hang = 1'b1;
    set_req(1, 32'h11111111, 32'h22222222, 3'd3, 3'd4);
    req_valid = 4'b0010;
    do_accept(1, waited);
    req_valid = 4'b0000;
    wait_rsp(go_cyc, rsp_n, rv, res, err, one_cyc, regrant);
    check("t3_go_cycles", go_cyc, 16);
    check("t3_rsp_cycle", rsp_n, 18);
    check("t3_rsp_valid", rv, 4'b0010);
    check("t3_rsp_error", err, 1);
    check("t3_rsp_result", res, 0);
    check("t3_idle", busy, 0);
    cm_hang = 1'b0; cm_k = 2; cm_result = 32'h12345678;
    set_req(3, 32'h33333333, 32'h44444444, 3'd0, 3'd5);
    req_valid = 4'b1000;
    do_accept(3, waited);
    req_valid = 4'b0000;
    wait_rsp(go_cyc, rsp_n, rv, res, err, one_cyc, regrant);
    check("t3b_rsp_valid", rv, 4'b1000);
    check("t3b_rsp_result", res, 32'h12345678);
    check("t3b_rsp_error", err, 0);

    // Slow release: done lingers 3 cycles after go falls; requester 0 waits meanwhile
    cm_k = 2; cm_hold = 3; cm_result = 32'h0BADF00D;
    bad_ready = 0;
    set_req(1, 32'h55555555, 32'h66666666, 3'd2, 3'd2);
    set_req(0, 32'h77777777, 32'h88888888, 3'd6, 3'd1);
    req_valid = 4'b0010;
    do_accept(1, waited);
    req_valid = 4'b0001;
    wait_rsp(go_cyc, rsp_n, rv, res, err, one_cyc, regrant);
    check("t4_go_cycles", go_cyc, 3);
    check("t4_rsp_cycle", rsp_n, 8);
    check("t4_rsp_result", res, 32'h0BADF00D);
    check("t4_no_early_go", regrant, 0);
    check("t4_no_ready_while_busy", bad_ready, 0);
    #1;
    check("t4_next_ready", req_ready, 4'b0001);
    cm_hold = 1;

    // Reset in the third RUN cycle: outputs clear without a clock edge
    cm_k = 10;
    do_accept(0, waited);
    req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    check("t5_pre_go", core_go, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_core_go", core_go, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cm_k = 1; cm_result = 32'hCAFE0000;
    set_req(3, 32'h99999999, 32'hAAAAAAAA, 3'd1, 3'd1);
    req_valid = 4'b1001;
    do_accept(0, waited);
    req_valid = 4'b0000;
    wait_rsp(go_cyc, rsp_n, rv, res, err, one_cyc, regrant);
    check("t5_rsp_valid", rv, 4'b0001);
    check("t5_rsp_result", res, 32'hCAFE0000);

    // Done arrives exactly on the last watchdog count: result wins
    cm_k = 15; cm_result = 32'hDEADBEEF;
    set_req(2, 32'hBBBBBBBB, 32'hCCCCCCCC, 3'd4, 3'd3);
    req_valid = 4'b0100;
    do_accept(2, waited);
    req_valid = 4'b0000;
    wait_rsp(go_cyc, rsp_n, rv, res, err, one_cyc, regrant);
    check("t6_go_cycles", go_cyc, 16);
    check("t6_rsp_cycle", rsp_n, 19);
    check("t6_rsp_valid", rv, 4'b0100);
    check("t6_rsp_error", err, 0);
    check("t6_rsp_result", res, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
